// File: rtl/arm_serial_rx_pkg.sv
// rtl/arm_serial_rx_pkg.sv - shared widths, timeout and FSM encodings for the serial receiver
package arm_serial_rx_pkg;

   localparam int A_W        = 7;
   localparam int D_W        = 8;
   localparam int TIMEOUT    = 64;
   // start + address + gap + data + gap + stop
   localparam int SLOT_COUNT = A_W + D_W + 4;

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int BIT_CNT_W = $clog2(maxInt(A_W, D_W) + 1);
   localparam int TO_CNT_W  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      GAP_A = 3'd2,
      DATA  = 3'd3,
      GAP_D = 3'd4,
      STOP  = 3'd5
   } rxState_t;

endpackage

// File: rtl/arm_serial_rx_if.sv
// rtl/arm_serial_rx_if.sv - serial line inputs and decoded-frame outputs of the receiver
interface arm_serial_rx_if;
   import arm_serial_rx_pkg::*;

   logic           InC;
   logic           InD;
   logic           InOE;
   logic [A_W-1:0] OutA;
   logic [D_W-1:0] OutDat;
   logic           Valid;
   logic           FrameErr;
   logic           Busy;

   modport master (
      output InC, InD, InOE,
      input  OutA, OutDat, Valid, FrameErr, Busy
   );

   modport slave (
      input  InC, InD, InOE,
      output OutA, OutDat, Valid, FrameErr, Busy
   );
endinterface

// File: rtl/arm_serial_rx_edge_det.sv
// rtl/arm_serial_rx_edge_det.sv - registers the serial lines and emits an aligned rising-edge slot strobe
module arm_serial_rx_edge_det (
   input  logic clk_in,
   input  logic reset,
   input  logic inC,
   input  logic inD,
   input  logic inOE,
   output logic slotEdge,
   output logic slotD,
   output logic slotOE
);
   logic inCQ, inCQQ, inDQ, inOEQ;

   // Register the lines once, then register the edge strobe together with the data it qualifies
   always_ff @(posedge clk_in) begin
      if (reset) begin
         inCQ     <= 1'b0;
         inCQQ    <= 1'b0;
         inDQ     <= 1'b0;
         inOEQ    <= 1'b0;
         slotEdge <= 1'b0;
         slotD    <= 1'b0;
         slotOE   <= 1'b0;
      end else begin
         inCQ     <= inC;
         inCQQ    <= inCQ;
         inDQ     <= inD;
         inOEQ    <= inOE;
         slotEdge <= inCQ & ~inCQQ;
         slotD    <= inDQ;
         slotOE   <= inOEQ;
      end
   end
endmodule

// File: rtl/arm_serial_rx.sv
// rtl/arm_serial_rx.sv - deserializes one address/data frame and flags framing errors and timeouts
module arm_serial_rx
   import arm_serial_rx_pkg::*;
(
   input  logic           clk_in,
   input  logic           reset,
   arm_serial_rx_if.slave bus
);
   rxState_t             state, nextState;
   logic                 slotEdge, slotD, slotOE;
   logic [BIT_CNT_W-1:0] bitCnt;
   logic [TO_CNT_W-1:0]  idleCnt;
   logic [A_W-1:0]       shA, outAQ;
   logic [D_W-1:0]       shD, outDatQ;
   logic                 validQ, frameErrQ;
   logic                 timedOut, frameDone, frameErr, shiftA, shiftD;

   arm_serial_rx_edge_det u_edge (
      .clk_in   (clk_in),
      .reset    (reset),
      .inC      (bus.InC),
      .inD      (bus.InD),
      .inOE     (bus.InOE),
      .slotEdge (slotEdge),
      .slotD    (slotD),
      .slotOE   (slotOE)
   );

   // A slot edge in the same cycle always wins over the timeout
   assign timedOut = (state != IDLE) && !slotEdge && (idleCnt == TO_CNT_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk_in) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state: advance one slot per edge, any malformed slot or timeout returns to IDLE
   always_comb begin
      nextState = state;
      if (timedOut) begin
         nextState = IDLE;
      end else if (slotEdge) begin
         case (state)
            IDLE:    if (slotOE && !slotD) nextState = ADDR;
            ADDR:    if (!slotOE) nextState = IDLE;
                     else if (bitCnt == BIT_CNT_W'(A_W - 1)) nextState = GAP_A;
            GAP_A:   nextState = slotOE ? IDLE : DATA;
            DATA:    if (!slotOE) nextState = IDLE;
                     else if (bitCnt == BIT_CNT_W'(D_W - 1)) nextState = GAP_D;
            GAP_D:   nextState = slotOE ? IDLE : STOP;
            STOP:    nextState = IDLE;
            default: nextState = IDLE;
         endcase
      end
   end

   // Outputs of the FSM: shift strobes, frame completion and error events
   always_comb begin
      frameDone = 1'b0;
      frameErr  = timedOut;
      shiftA    = 1'b0;
      shiftD    = 1'b0;
      if (slotEdge) begin
         case (state)
            IDLE:    frameErr = slotOE && slotD;
            ADDR:    begin shiftA = slotOE; frameErr = !slotOE; end
            GAP_A:   frameErr = slotOE;
            DATA:    begin shiftD = slotOE; frameErr = !slotOE; end
            GAP_D:   frameErr = slotOE;
            STOP:    if (slotOE && !slotD) frameDone = 1'b1;
                     else frameErr = 1'b1;
            default: frameErr = 1'b1;
         endcase
      end
   end

   // Datapath: shift registers, bit and idle counters, held outputs and one-cycle pulses
   always_ff @(posedge clk_in) begin
      if (reset) begin
         shA       <= '0;
         shD       <= '0;
         bitCnt    <= '0;
         idleCnt   <= '0;
         outAQ     <= '0;
         outDatQ   <= '0;
         validQ    <= 1'b0;
         frameErrQ <= 1'b0;
      end else begin
         validQ    <= frameDone;
         frameErrQ <= frameErr;
         if (frameErr) begin
            shA     <= '0;
            shD     <= '0;
            bitCnt  <= '0;
            idleCnt <= '0;
         end else begin
            if (slotEdge || state == IDLE) idleCnt <= '0;
            else if (idleCnt != '1)        idleCnt <= idleCnt + TO_CNT_W'(1);
            if (shiftA) begin
               shA    <= {shA[A_W-2:0], slotD};
               bitCnt <= (bitCnt == BIT_CNT_W'(A_W - 1)) ? '0 : bitCnt + BIT_CNT_W'(1);
            end
            if (shiftD) begin
               shD    <= {shD[D_W-2:0], slotD};
               bitCnt <= (bitCnt == BIT_CNT_W'(D_W - 1)) ? '0 : bitCnt + BIT_CNT_W'(1);
            end
            if (frameDone) begin
               outAQ   <= shA;
               outDatQ <= shD;
               shA     <= '0;
               shD     <= '0;
            end
         end
      end
   end

   assign bus.OutA     = outAQ;
   assign bus.OutDat   = outDatQ;
   assign bus.Valid    = validQ;
   assign bus.FrameErr = frameErrQ;
   assign bus.Busy     = (state != IDLE);
endmodule

// File: tb/tb_arm_serial_rx.sv
// tb/tb_arm_serial_rx.sv - directed and randomized frame checks against a slot-level frame model
module tb_arm_serial_rx;
   import arm_serial_rx_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   arm_serial_rx_if rxBus ();

   arm_serial_rx dut (
      .clk_in (clk),
      .reset  (reset),
      .bus    (rxBus)
   );

   int nCmp = 0;
   int nBad = 0;
   int cycleCnt = 0;
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Monitor: count pulse cycles and capture the outputs on each Valid
   int validCnt = 0, errCnt = 0, lastValidCyc = 0;
   bit bothHigh = 1'b0;
   logic [A_W-1:0] obsA[$];
   logic [D_W-1:0] obsD[$];
   always @(negedge clk) begin
      if (rxBus.Valid === 1'b1) begin
         validCnt++;
         lastValidCyc = cycleCnt;
         obsA.push_back(rxBus.OutA);
         obsD.push_back(rxBus.OutDat);
      end
      if (rxBus.FrameErr === 1'b1) errCnt++;
      if (rxBus.Valid === 1'b1 && rxBus.FrameErr === 1'b1) bothHigh = 1'b1;
   end

   // Reference model state
   int expV = 0, expE = 0, obsIdx = 0, riseCyc = 0;
   logic [A_W-1:0] modelA = '0;
   logic [D_W-1:0] modelD = '0;
   logic [A_W-1:0] expAq[$];
   logic [D_W-1:0] expDq[$];
   bit frOe[SLOT_COUNT];
   bit frD[SLOT_COUNT];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nBad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sendSlot(input bit oe, input bit d);
      rxBus.InC  = 1'b0;
      rxBus.InOE = oe;
      rxBus.InD  = d;
      tick(2);
      rxBus.InC = 1'b1;
      riseCyc   = cycleCnt;
      tick(2);
   endtask

   task automatic idle(input int n);
      rxBus.InC  = 1'b0;
      rxBus.InOE = 1'b0;
      rxBus.InD  = 1'b0;
      tick(n);
   endtask

   task automatic buildFrame(input logic [A_W-1:0] a, input logic [D_W-1:0] d);
      frOe[0] = 1'b1; frD[0] = 1'b0;
      for (int i = 0; i < A_W; i++) begin frOe[1+i] = 1'b1; frD[1+i] = a[A_W-1-i]; end
      frOe[A_W+1] = 1'b0; frD[A_W+1] = 1'($urandom_range(0, 1));
      for (int i = 0; i < D_W; i++) begin frOe[A_W+2+i] = 1'b1; frD[A_W+2+i] = d[D_W-1-i]; end
      frOe[A_W+D_W+2] = 1'b0; frD[A_W+D_W+2] = 1'($urandom_range(0, 1));
      frOe[SLOT_COUNT-1] = 1'b1; frD[SLOT_COUNT-1] = 1'b0;
   endtask

   // Index of the first slot breaking the frame rules, -1 for a well-formed frame
   function automatic int firstBad();
      bit isGap, isMark;
      for (int i = 0; i < SLOT_COUNT; i++) begin
         isGap  = (i == A_W + 1) || (i == A_W + D_W + 2);
         isMark = (i == 0) || (i == SLOT_COUNT - 1);
         if (isGap ? frOe[i] : (!frOe[i] || (isMark && frD[i]))) return i;
      end
      return -1;
   endfunction

   // Send the frame up to its first bad slot and record what the receiver must report
   task automatic sendFrame();
      int bad, n;
      logic [A_W-1:0] a;
      logic [D_W-1:0] d;
      bad = firstBad();
      n   = (bad < 0) ? SLOT_COUNT : bad + 1;
      for (int i = 0; i < n; i++) sendSlot(frOe[i], frD[i]);
      if (bad < 0) begin
         for (int i = 0; i < A_W; i++) a[A_W-1-i] = frD[1+i];
         for (int i = 0; i < D_W; i++) d[D_W-1-i] = frD[A_W+2+i];
         modelA = a;
         modelD = d;
         expV++;
         expAq.push_back(a);
         expDq.push_back(d);
      end else begin
         expE++;
      end
   endtask

   task automatic checkAll(input string tag);
      check({tag, ".valid"}, 32'(validCnt), 32'(expV));
      check({tag, ".err"}, 32'(errCnt), 32'(expE));
      check({tag, ".outA"}, 32'(rxBus.OutA), 32'(modelA));
      check({tag, ".outDat"}, 32'(rxBus.OutDat), 32'(modelD));
      while (obsIdx < obsA.size() && obsIdx < expAq.size()) begin
         check({tag, ".pulseA"}, 32'(obsA[obsIdx]), 32'(expAq[obsIdx]));
         check({tag, ".pulseD"}, 32'(obsD[obsIdx]), 32'(expDq[obsIdx]));
         obsIdx++;
      end
   endtask

   initial begin
      int k;
      reset = 1'b1;
      idle(3);
      check("rst.outA", 32'(rxBus.OutA), 32'h0);
      check("rst.outDat", 32'(rxBus.OutDat), 32'h0);
      check("rst.valid", 32'(rxBus.Valid), 32'h0);
      check("rst.err", 32'(rxBus.FrameErr), 32'h0);
      check("rst.busy", 32'(rxBus.Busy), 32'h0);
      reset = 1'b0;
      idle(2);

      buildFrame(7'h7F, 8'hFF);
      sendFrame();
      idle(4);
      checkAll("t1");

      buildFrame(7'h41, 8'h9F);
      sendFrame();
      idle(4);
      check("t2.latency", 32'(lastValidCyc - riseCyc), 32'd3);
      checkAll("t2");

      buildFrame(7'h12, 8'h34);
      frOe[A_W+1] = 1'b1;
      sendFrame();
      idle(4);
      checkAll("t3");

      buildFrame(7'h66, 8'h11);
      frD[SLOT_COUNT-1] = 1'b1;
      sendFrame();
      idle(4);
      checkAll("t4.bad");
      buildFrame(7'h01, 8'h80);
      sendFrame();
      idle(4);
      checkAll("t4.good");

      buildFrame(7'h15, 8'h3C);
      for (int i = 0; i < 4; i++) sendSlot(frOe[i], frD[i]);
      idle(64);
      idle(10);
      expE++;
      check("t5.busy", 32'(rxBus.Busy), 32'h0);
      checkAll("t5.timeout");
      buildFrame(7'h5B, 8'hC3);
      sendFrame();
      idle(4);
      checkAll("t5.next");

      buildFrame(7'h33, 8'h5A);
      for (int i = 0; i < A_W + 5; i++) sendSlot(frOe[i], frD[i]);
      rxBus.InC  = 1'b0;
      rxBus.InOE = 1'b0;
      reset      = 1'b1;
      tick(1);
      reset = 1'b0;
      modelA = '0;
      modelD = '0;
      check("t6.rstBusy", 32'(rxBus.Busy), 32'h0);
      check("t6.rstValid", 32'(rxBus.Valid), 32'h0);
      check("t6.rstErr", 32'(rxBus.FrameErr), 32'h0);
      idle(8);
      checkAll("t6.rst");

      buildFrame(7'h55, 8'hAA);
      sendFrame();
      buildFrame(7'h2A, 8'h55);
      sendFrame();
      idle(4);
      checkAll("t6.b2b");

      for (int f = 0; f < 20; f++) begin
         buildFrame(A_W'($urandom), D_W'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            k = $urandom_range(1, SLOT_COUNT - 1);
            if (k == A_W + 1 || k == A_W + D_W + 2) frOe[k] = 1'b1;
            else if (k == SLOT_COUNT - 1) begin
               if ($urandom_range(0, 1) == 1) frD[k] = 1'b1;
               else frOe[k] = 1'b0;
            end else frOe[k] = 1'b0;
         end
         sendFrame();
         idle(4);
         checkAll("rand");
      end

      check("never.both", 32'(bothHigh), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
